// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential RV32M multiplier.
package mul_seq_pkg;

   localparam int unsigned DATA_BUS_WIDTH = 32;

   typedef logic [1:0] mul_op_t;

   localparam mul_op_t MUL_OP_MUL    = 2'b00;
   localparam mul_op_t MUL_OP_MULH   = 2'b01;
   localparam mul_op_t MUL_OP_MULHSU = 2'b10;
   localparam mul_op_t MUL_OP_MULHU  = 2'b11;

   // rs1 is treated as signed by MULH and MULHSU
   function automatic logic op1_is_signed(mul_op_t op);
      return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
   endfunction

   function automatic logic op2_is_signed(mul_op_t op);
      return (op == MUL_OP_MULH);
   endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Request/response bundle between the EX stage and the multiplier.
interface mul_seq_if
   import mul_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_BUS_WIDTH
) ();

   logic             start;
   logic             cancel;
   mul_op_t          mul_op;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] op2;
   logic             busy;
   logic             result_valid;
   logic [WIDTH-1:0] result;

   modport master (
      output start, cancel, mul_op, op1, op2,
      input  busy, result_valid, result
   );

   modport slave (
      input  start, cancel, mul_op, op1, op2,
      output busy, result_valid, result
   );

endinterface

// File: rtl/mul_add_row.sv
// One shift-add row: conditionally adds the multiplicand into the accumulator
// high half, keeping the carry so the following right shift is lossless.
module mul_add_row #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] mcand,
   input  logic             en,
   output logic [WIDTH:0]   sum_c
);

   assign sum_c = en ? ({1'b0, acc_hi} + {1'b0, mcand}) : {1'b0, acc_hi};

endmodule

// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes up front; the sign is reapplied at the end.
module mul_seq
   import mul_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_BUS_WIDTH,
   parameter int unsigned CNT_W = 6
) (
   input  logic     clk,
   input  logic     rst,
   mul_seq_if.slave bus
);

   localparam int unsigned PW = 2 * WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic             busy_q;
   logic             valid_q;
   logic [WIDTH-1:0] result_q;

   mul_op_t          op_q;
   logic             neg_q;
   logic [PW-1:0]    acc_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [CNT_W-1:0] cnt_q;

   logic             accept_c;
   logic             step_c;
   logic             valid_next;
   logic             busy_next;
   logic             sign1_c;
   logic             sign2_c;
   logic [WIDTH-1:0] mag1_c;
   logic [WIDTH-1:0] mag2_c;
   logic [WIDTH:0]   sum_c;
   logic [PW-1:0]    prod_c;

   // Magnitudes; the most-negative value maps onto itself, read as unsigned
   always_comb begin
      sign1_c = op1_is_signed(bus.mul_op) & bus.op1[WIDTH-1];
      sign2_c = op2_is_signed(bus.mul_op) & bus.op2[WIDTH-1];
      mag1_c  = sign1_c ? WIDTH'(-bus.op1) : bus.op1;
      mag2_c  = sign2_c ? WIDTH'(-bus.op2) : bus.op2;
      prod_c  = neg_q ? PW'(-acc_q) : acc_q;
   end

   mul_add_row #(.WIDTH(WIDTH)) u_row (
      .acc_hi (acc_q[PW-1:WIDTH]),
      .mcand  (mcand_q),
      .en     (mplier_q[0]),
      .sum_c  (sum_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      step_c     = 1'b0;
      valid_next = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start && !bus.cancel) begin
               state_next = S_CALC;
               accept_c   = 1'b1;
            end
         end
         S_CALC: begin
            if (bus.cancel) begin
               state_next = S_IDLE;
            end else begin
               step_c = 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_next = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
            valid_next = !bus.cancel;
         end
         default: state_next = S_IDLE;
      endcase
      busy_next = (state_next != S_IDLE);
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= MUL_OP_MUL;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= '0;
      end else begin
         busy_q  <= busy_next;
         valid_q <= valid_next;
         if (accept_c) begin
            op_q     <= bus.mul_op;
            neg_q    <= sign1_c ^ sign2_c;
            acc_q    <= '0;
            mcand_q  <= mag1_c;
            mplier_q <= mag2_c;
            cnt_q    <= '0;
         end else if (step_c) begin
            acc_q    <= {sum_c, acc_q[WIDTH-1:1]};
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
         end
         if (valid_next) begin
            result_q <= (op_q == MUL_OP_MUL) ? prod_c[WIDTH-1:0] : prod_c[PW-1:WIDTH];
         end
      end
   end

   assign bus.busy         = busy_q;
   assign bus.result_valid = valid_q;
   assign bus.result       = result_q;

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: directed corner cases, flush/contention,
// async reset and a long back-to-back random run against a 64-bit model.
module tb_mul_seq;
   import mul_seq_pkg::*;

   localparam int unsigned W = 32;

   typedef struct {
      logic [W-1:0] val;
      int           acc;
   } exp_t;

   logic clk;
   logic rst;
   mul_seq_if #(.WIDTH(W)) bus ();

   mul_seq #(.WIDTH(W), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int           total = 0;
   int           bad   = 0;
   int           cyc   = 0;
   exp_t         sb[$];
   exp_t         mon_e;
   logic [W-1:0] last_res;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Reference: plain 64-bit arithmetic on sign- or zero-extended operands
   function automatic logic [W-1:0] ref_mul(input mul_op_t op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      longint       ae;
      longint       be;
      logic [63:0]  p;
      if (op == MUL_OP_MULH || op == MUL_OP_MULHSU) ae = longint'($signed(a));
      else                                           ae = longint'({32'b0, a});
      if (op == MUL_OP_MULH) be = longint'($signed(b));
      else                   be = longint'({32'b0, b});
      p = 64'(ae * be);
      return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return W'($urandom);
      endcase
   endfunction

   // Monitor: every result pulse must match the oldest outstanding request
   always @(negedge clk) begin
      if (!rst && bus.result_valid === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got result %h want no result", bus.result);
         end else begin
            mon_e = sb.pop_front();
            check("result", bus.result, mon_e.val);
            check("latency", W'(cyc - mon_e.acc), W'(33));
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (bus.busy !== 1'b0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("FAIL wait_idle: busy got 1 want 0");
      end
   endtask

   task automatic issue(input mul_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] expv, input bit push);
      exp_t e;
      wait_idle();
      bus.start  = 1'b1;
      bus.mul_op = op;
      bus.op1    = a;
      bus.op2    = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("accept_busy", W'(bus.busy), W'(1));
      if (push) begin
         e.val = expv;
         e.acc = cyc;
         sb.push_back(e);
         last_res = expv;
      end
   endtask

   initial begin
      int           n;
      mul_op_t      op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      exp_t         e;

      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      bus.mul_op = MUL_OP_MUL;
      bus.op1    = '0;
      bus.op2    = '0;
      last_res   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", W'(bus.busy), '0);
      check("rst_valid", W'(bus.result_valid), '0);
      check("rst_result", bus.result, '0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic MUL with busy-length measurement
      issue(MUL_OP_MUL, 32'd7, 32'd6, 32'd42, 1'b1);
      n = 0;
      @(negedge clk);
      while (bus.busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles", W'(n), W'(33));
      @(posedge clk);
      #1;

      issue(MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
      issue(MUL_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
      issue(MUL_OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1);
      issue(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      issue(MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);

      // Flush in the middle of CALC
      issue(MUL_OP_MUL, 32'd12345, 32'd678, '0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      bus.cancel = 1'b1;
      @(posedge clk);
      #1;
      bus.cancel = 1'b0;
      check("cancel_busy", W'(bus.busy), '0);
      repeat (40) @(posedge clk);
      #1;
      check("cancel_result_held", bus.result, last_res);

      // start with cancel in IDLE is refused
      bus.start  = 1'b1;
      bus.cancel = 1'b1;
      bus.op1    = 32'd9;
      bus.op2    = 32'd9;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      check("start_cancel_busy", W'(bus.busy), '0);
      repeat (40) @(posedge clk);
      #1;

      // start while busy is ignored
      issue(MUL_OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0,
            ref_mul(MUL_OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 1'b1);
      repeat (5) @(posedge clk);
      #1;
      bus.start  = 1'b1;
      bus.mul_op = MUL_OP_MUL;
      bus.op1    = 32'd1;
      bus.op2    = 32'd1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_idle();
      repeat (40) @(posedge clk);
      #1;
      check("busy_start_ignored", W'(sb.size()), '0);

      // Asynchronous reset between edges, then recovery
      issue(MUL_OP_MUL, 32'd1000, 32'd1000, '0, 1'b0);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", W'(bus.busy), '0);
      check("arst_valid", W'(bus.result_valid), '0);
      check("arst_result", bus.result, '0);
      last_res = '0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      issue(MUL_OP_MUL, 32'd3, 32'd5, 32'd15, 1'b1);

      // Back-to-back with start held: one acceptance every 34 edges
      wait_idle();
      for (int i = 0; i < 1000; i++) begin
         op = mul_op_t'($urandom_range(0, 3));
         a  = pick();
         b  = pick();
         bus.start  = 1'b1;
         bus.mul_op = op;
         bus.op1    = a;
         bus.op2    = b;
         @(posedge clk);
         #1;
         e.val = ref_mul(op, a, b);
         e.acc = cyc;
         sb.push_back(e);
         if (i != 999) begin
            repeat (33) @(posedge clk);
            #1;
         end
      end
      bus.start = 1'b0;

      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", W'(sb.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
